// File: rtl/accumulator_alu.sv
// -----------------------------------------------------------------------------
// accumulator_alu
//
// 8-bit accumulator ALU with a carry/borrow flag. On every rising clk edge with
// acc_ce=1 the 4-bit opcode is applied to the accumulator (A) and the operand
// data_in (B). The result is written back to the accumulator, and the carry
// flag is updated for the opcodes that define it. Both outputs come straight
// from flops, so there is no combinational path from any input to an output.
//
// Ports:
//   clk       in   1  system clock, all state updates on the rising edge
//   rst       in   1  asynchronous, active-low reset (ACC=0x00, CY=0)
//   opcode    in   4  operation select, sampled when acc_ce=1
//   data_in   in   8  operand B, sampled together with opcode
//   acc_ce    in   1  1 = execute opcode on this edge, 0 = hold all state
//   cy        out  1  carry/borrow flag register
//   data_out  out  8  accumulator register
// -----------------------------------------------------------------------------
module accumulator_alu (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic [7:0] data_in,
  input  logic       acc_ce,
  output logic       cy,
  output logic [7:0] data_out
);

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LD  = 4'h1,
    OP_ADD = 4'h2,
    OP_ADC = 4'h3,
    OP_SUB = 4'h4,
    OP_SBB = 4'h5,
    OP_AND = 4'h6,
    OP_OR  = 4'h7,
    OP_XOR = 4'h8,
    OP_NOT = 4'h9,
    OP_SHL = 4'hA,
    OP_SHR = 4'hB,
    OP_ROL = 4'hC,
    OP_ROR = 4'hD,
    OP_CLR = 4'hE,
    OP_INC = 4'hF
  } op_e;

  // 9-bit sum: bit 8 is the carry-out.
  function automatic logic [8:0] add9(input logic [7:0] a,
                                      input logic [7:0] b,
                                      input logic       ci);
    return {1'b0, a} + {1'b0, b} + {8'd0, ci};
  endfunction

  // 9-bit difference: bit 8 is the borrow (set when a < b + bi). The
  // wrap of the zero-extended subtraction sets bit 8 exactly on underflow.
  function automatic logic [8:0] sub9(input logic [7:0] a,
                                      input logic [7:0] b,
                                      input logic       bi);
    return {1'b0, a} - {1'b0, b} - {8'd0, bi};
  endfunction

  logic [7:0] acc_q;
  logic [7:0] acc_d;
  logic       cy_q;
  logic       cy_d;
  logic [8:0] sum_s;
  logic [8:0] dif_s;

  // Shared adder/subtractor; the carry-in is forced low for ADD/SUB/INC.
  always_comb begin
    sum_s = 9'd0;
    dif_s = 9'd0;
    if (opcode == OP_ADC) begin
      sum_s = add9(acc_q, data_in, cy_q);
    end else if (opcode == OP_INC) begin
      sum_s = add9(acc_q, 8'h01, 1'b0);
    end else begin
      sum_s = add9(acc_q, data_in, 1'b0);
    end
    if (opcode == OP_SBB) begin
      dif_s = sub9(acc_q, data_in, cy_q);
    end else begin
      dif_s = sub9(acc_q, data_in, 1'b0);
    end
  end

  // Next-state decode: hold by default, execute the opcode only when enabled.
  // Gating on acc_ce first keeps X on opcode/data_in from reaching the state.
  always_comb begin
    acc_d = acc_q;
    cy_d  = cy_q;
    if (acc_ce) begin
      case (opcode)
        OP_NOP: begin
          acc_d = acc_q;
          cy_d  = cy_q;
        end
        OP_LD: begin
          acc_d = data_in;
        end
        OP_ADD, OP_ADC, OP_INC: begin
          acc_d = sum_s[7:0];
          cy_d  = sum_s[8];
        end
        OP_SUB, OP_SBB: begin
          acc_d = dif_s[7:0];
          cy_d  = dif_s[8];
        end
        OP_AND: begin
          acc_d = acc_q & data_in;
        end
        OP_OR: begin
          acc_d = acc_q | data_in;
        end
        OP_XOR: begin
          acc_d = acc_q ^ data_in;
        end
        OP_NOT: begin
          acc_d = ~acc_q;
        end
        OP_SHL: begin
          acc_d = {acc_q[6:0], 1'b0};
          cy_d  = acc_q[7];
        end
        OP_SHR: begin
          acc_d = {1'b0, acc_q[7:1]};
          cy_d  = acc_q[0];
        end
        OP_ROL: begin
          acc_d = {acc_q[6:0], acc_q[7]};
          cy_d  = acc_q[7];
        end
        OP_ROR: begin
          acc_d = {acc_q[0], acc_q[7:1]};
          cy_d  = acc_q[0];
        end
        OP_CLR: begin
          acc_d = 8'h00;
          cy_d  = 1'b0;
        end
        default: begin
          acc_d = acc_q;
          cy_d  = cy_q;
        end
      endcase
    end else begin
      acc_d = acc_q;
      cy_d  = cy_q;
    end
  end

  // Accumulator and carry registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= 8'h00;
      cy_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cy_q  <= cy_d;
    end
  end

  assign data_out = acc_q;
  assign cy       = cy_q;

endmodule

// File: tb/tb_accumulator_alu.sv
// -----------------------------------------------------------------------------
// tb_accumulator_alu
//
// Self-checking bench for accumulator_alu. A table of directed vectors with
// hand-derived expected results, a randomized run checked against an
// arithmetic reference model, enable gating with random inputs, and
// asynchronous reset behaviour. Expected results are queued when stimulus
// is driven and popped when the result is sampled after the clock edge.
// -----------------------------------------------------------------------------
module tb_accumulator_alu;

  logic       clk;
  logic       rst;
  logic [3:0] opcode;
  logic [7:0] data_in;
  logic       acc_ce;
  logic       cy;
  logic [7:0] data_out;

  accumulator_alu dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .data_in  (data_in),
    .acc_ce   (acc_ce),
    .cy       (cy),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] b;
    logic       ce;
    logic [7:0] acc;
    logic       cy;
  } vec_t;

  typedef struct {
    logic [7:0] acc;
    logic       cy;
  } exp_t;

  localparam int NVEC = 25;
  vec_t vecs [NVEC];
  exp_t sb_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] m_acc;
  logic       m_cy;

  task automatic check(input string name, input logic [7:0] act_acc,
                       input logic act_cy, input logic [7:0] exp_acc,
                       input logic exp_cy);
    n_tests++;
    if (act_acc !== exp_acc || act_cy !== exp_cy) begin
      n_fail++;
      $display("FAIL %s: got acc=%02h cy=%0b, expected acc=%02h cy=%0b",
               name, act_acc, act_cy, exp_acc, exp_cy);
    end
  endtask

  // Drive one operation, queue its expectation, then sample after the edge.
  task automatic step(input string name, input logic [3:0] op,
                      input logic [7:0] b, input logic ce,
                      input logic [7:0] e_acc, input logic e_cy);
    exp_t e;
    @(negedge clk);
    opcode  = op;
    data_in = b;
    acc_ce  = ce;
    e.acc   = e_acc;
    e.cy    = e_cy;
    sb_q.push_back(e);
    @(posedge clk);
    #2;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      check(name, data_out, cy, e.acc, e.cy);
    end
  endtask

  // Reference model written in integer arithmetic.
  task automatic model(input logic [3:0] op, input logic [7:0] b,
                       input logic ce, inout logic [7:0] acc,
                       inout logic c);
    int a, bb, ci, r;
    a  = int'(acc);
    bb = int'(b);
    ci = c ? 1 : 0;
    r  = a;
    if (ce) begin
      case (op)
        4'h1: r = bb;
        4'h2: begin r = a + bb;      c = (r > 255); end
        4'h3: begin r = a + bb + ci; c = (r > 255); end
        4'h4: begin r = a - bb;      c = (a < bb); end
        4'h5: begin r = a - bb - ci; c = (a < bb + ci); end
        4'h6: r = a & bb;
        4'h7: r = a | bb;
        4'h8: r = a ^ bb;
        4'h9: r = 255 - a;
        4'hA: begin c = (a >= 128); r = a * 2; end
        4'hB: begin c = (a % 2 == 1); r = a / 2; end
        4'hC: begin c = (a >= 128); r = a * 2 + a / 128; end
        4'hD: begin c = (a % 2 == 1); r = a / 2 + (a % 2) * 128; end
        4'hE: begin r = 0; c = 1'b0; end
        4'hF: begin r = a + 1; c = (r > 255); end
        default: r = a;
      endcase
    end
    acc = r[7:0];
  endtask

  initial begin
    // op, b, ce, expected acc, expected cy (state before row 0: 00/0)
    vecs[0]  = '{4'h1, 8'h5A, 1'b1, 8'h5A, 1'b0}; // LD 5A
    vecs[1]  = '{4'h0, 8'h33, 1'b1, 8'h5A, 1'b0}; // NOP
    vecs[2]  = '{4'h1, 8'hF0, 1'b1, 8'hF0, 1'b0}; // LD F0
    vecs[3]  = '{4'h2, 8'h20, 1'b1, 8'h10, 1'b1}; // ADD 20
    vecs[4]  = '{4'h3, 8'h01, 1'b1, 8'h12, 1'b0}; // ADC 01
    vecs[5]  = '{4'h1, 8'hFF, 1'b1, 8'hFF, 1'b0}; // LD FF
    vecs[6]  = '{4'hF, 8'h00, 1'b1, 8'h00, 1'b1}; // INC wraps
    vecs[7]  = '{4'h1, 8'hCC, 1'b1, 8'hCC, 1'b1}; // LD keeps cy
    vecs[8]  = '{4'h6, 8'hAA, 1'b1, 8'h88, 1'b1}; // AND
    vecs[9]  = '{4'h7, 8'h03, 1'b1, 8'h8B, 1'b1}; // OR
    vecs[10] = '{4'h8, 8'hFF, 1'b1, 8'h74, 1'b1}; // XOR
    vecs[11] = '{4'h9, 8'h55, 1'b1, 8'h8B, 1'b1}; // NOT ignores B
    vecs[12] = '{4'hE, 8'h00, 1'b0, 8'h8B, 1'b1}; // CLR gated off
    vecs[13] = '{4'h1, 8'h10, 1'b1, 8'h10, 1'b1}; // LD 10
    vecs[14] = '{4'h4, 8'h20, 1'b1, 8'hF0, 1'b1}; // SUB borrow
    vecs[15] = '{4'h5, 8'h0F, 1'b1, 8'hE0, 1'b0}; // SBB with borrow in
    vecs[16] = '{4'h1, 8'h10, 1'b1, 8'h10, 1'b0}; // LD 10
    vecs[17] = '{4'h4, 8'h10, 1'b1, 8'h00, 1'b0}; // SUB equal
    vecs[18] = '{4'h1, 8'h81, 1'b1, 8'h81, 1'b0}; // LD 81
    vecs[19] = '{4'hA, 8'h00, 1'b1, 8'h02, 1'b1}; // SHL
    vecs[20] = '{4'hD, 8'h00, 1'b1, 8'h01, 1'b0}; // ROR
    vecs[21] = '{4'hD, 8'h00, 1'b1, 8'h80, 1'b1}; // ROR
    vecs[22] = '{4'hC, 8'h00, 1'b1, 8'h01, 1'b1}; // ROL
    vecs[23] = '{4'hB, 8'h00, 1'b1, 8'h00, 1'b1}; // SHR
    vecs[24] = '{4'hE, 8'h00, 1'b1, 8'h00, 1'b0}; // CLR

    // Reset asserted from time zero while an enabled LD FF is presented.
    rst     = 1'b0;
    acc_ce  = 1'b1;
    opcode  = 4'h1;
    data_in = 8'hFF;
    #1;
    check("reset_async_t0", data_out, cy, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("reset_dominates_ce", data_out, cy, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Directed table.
    for (int i = 0; i < NVEC; i++) begin
      step($sformatf("vec%0d", i), vecs[i].op, vecs[i].b, vecs[i].ce,
           vecs[i].acc, vecs[i].cy);
    end
    m_acc = vecs[NVEC-1].acc;
    m_cy  = vecs[NVEC-1].cy;

    // Randomized operations against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
      logic [7:0] b;
      logic       ce;
      op = 4'($urandom_range(15, 0));
      b  = 8'($urandom_range(255, 0));
      ce = ($urandom_range(3, 0) != 0);
      model(op, b, ce, m_acc, m_cy);
      step($sformatf("rand%0d_op%0h", i, op), op, b, ce, m_acc, m_cy);
    end

    // Enable gating: establish a nonzero state, then 20 disabled cycles.
    step("gate_ld", 4'h1, 8'hA5, 1'b1, 8'hA5, m_cy);
    step("gate_shl", 4'hA, 8'h00, 1'b1, 8'h4A, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step($sformatf("gate%0d", i), 4'($urandom_range(15, 0)),
           8'($urandom_range(255, 0)), 1'b0, 8'h4A, 1'b1);
    end

    // Asynchronous reset between edges clears the outputs before next edge.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("reset_midcycle", data_out, cy, 8'h00, 1'b0);
    @(negedge clk);
    acc_ce  = 1'b1;
    opcode  = 4'h1;
    data_in = 8'hFF;
    @(posedge clk);
    #2;
    check("reset_held_edge", data_out, cy, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step("post_reset_ld", 4'h1, 8'h3C, 1'b1, 8'h3C, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/accumulator_alu.md
# accumulator_alu

8-bit accumulator ALU with a carry flag. Each enabled clock cycle it applies a 4-bit opcode to the accumulator register and an 8-bit operand. The result is written back into the accumulator. It is the execution core under the layered-bench environment, driven through the DUT interface bundle. Both outputs are registered.

## Interface
Parameters: none. Widths are fixed.
- clk  input  1  single system clock; all state updates on its rising edge
- rst  input  1  reset, asynchronous, active-low; one clock
- opcode  input  4  operation select, sampled at rising clk when acc_ce=1
- data_in  input  8  operand B, sampled together with opcode
- acc_ce  input  1  accumulator clock enable; 1 = execute opcode this edge, 0 = hold all state
- cy  output  1  carry/borrow flag register
- data_out  output  8  accumulator register (ACC), driven directly from the flop

## Operation
- State is ACC[7:0] and CY. data_out=ACC and cy=CY at all times; there is no combinational path from inputs to outputs.
- Opcode map (A=ACC, B=data_in). Results are written to ACC. CY is updated only where stated, otherwise it holds.
  - 0x0 NOP: hold.
  - 0x1 LD: A<=B.
  - 0x2 ADD: {CY,A}<=A+B (9-bit sum).
  - 0x3 ADC: {CY,A}<=A+B+CY.
  - 0x4 SUB: A<=A-B; CY<=1 if A<B unsigned (borrow), else 0.
  - 0x5 SBB: A<=A-B-CY; CY<=borrow of the 9-bit subtraction.
  - 0x6 AND: A<=A&B.
  - 0x7 OR: A<=A|B.
  - 0x8 XOR: A<=A^B.
  - 0x9 NOT: A<=~A; B is ignored.
  - 0xA SHL: CY<=A[7]; A<={A[6:0],0}.
  - 0xB SHR: CY<=A[0]; A<={0,A[7:1]} (logical shift).
  - 0xC ROL: A<={A[6:0],A[7]}; CY<=A[7].
  - 0xD ROR: A<={A[0],A[7:1]}; CY<=A[0].
  - 0xE CLR: A<=0; CY<=0.
  - 0xF INC: {CY,A}<=A+1.
- All arithmetic is unsigned modulo 256. The carry-out/borrow is the 9th bit. There are no overflow or zero flags.
- With acc_ce=0, opcode and data_in are don't-care and ACC/CY hold regardless of their values (including X).

## Timing
- Reset: rst=0 forces ACC=0x00 and CY=0 immediately, with no clock edge needed. Reset dominates acc_ce.
- Reset release: the first rising edge with rst=1 may execute. Release is not required to be synchronized internally; the system drives deassertion away from the clk edge.
- Latency: 1 cycle. Inputs are sampled at edge N with acc_ce=1; the result appears on data_out/cy immediately after edge N and is stable for edge N+1.
- Back-to-back: one operation per cycle at full rate. Each operation uses the ACC/CY produced by the previous edge (e.g. an ADD then ADC chain forms a 16-bit add).
- Reset mid-operation: an asserted rst overrides any pending enabled edge. No partial result survives.
- No handshake and no busy state: every enabled edge completes.

## Test plan
- Reset: hold rst=0 while toggling acc_ce=1 with opcode=LD, B=0xFF → data_out=0x00, cy=0. Release rst, then LD 0x5A → data_out=0x5A after one edge.
- Add/carry chain: LD 0xF0, ADD 0x20 → 0x10, cy=1. Then ADC 0x01 → 0x12, cy=0. INC from 0xFF → 0x00, cy=1.
- Subtract/borrow: LD 0x10, SUB 0x20 → 0xF0, cy=1. Then SBB 0x0F → 0xE0, cy=0. SUB 0x10 on 0x10 → 0x00, cy=0.
- Logic: LD 0xCC, then AND 0xAA → 0x88, OR 0x03 → 0x8B, XOR 0xFF → 0x74, NOT → 0x8B. cy is unchanged throughout.
- Shifts/rotates: LD 0x81, then SHL → 0x02, cy=1. ROR → 0x01, cy=0. ROR → 0x80, cy=1. ROL → 0x01, cy=1. SHR → 0x00, cy=1. CLR → 0x00, cy=0.
- Enable gating: with acc_ce=0, apply random opcode/data_in for 20 cycles → data_out and cy are unchanged. Then assert rst=0 asynchronously between clock edges → outputs go to 0 before the next edge.
